ram_copy_engine: RTL and testbench

RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

---
 rtl/ram_copy_engine_pkg.sv | 19 +
 rtl/ram_copy_addr_gen.sv | 50 +++++
 rtl/ram_copy_engine.sv | 139 +++++++++++++
 tb/tb_ram_copy_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_copy_engine_pkg.sv
// Shared defaults, FSM encoding and the overlap-direction helper for the RAM copy engine.
package ram_copy_engine_pkg;

  localparam int WORDSIZE_DEF  = 8;
  localparam int ADDR_SIZE_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } copy_state_t;

  // Copy backwards when the destination starts inside the source window.
  function automatic logic overlap_desc(input int unsigned diff, input int unsigned len);
    return (diff != 32'd0) && (diff < len);
  endfunction

endpackage

// File: rtl/ram_copy_addr_gen.sv
// Loadable modulo-2^ADDR_SIZE up/down pointer; addr_nxt is the value after this edge.
module ram_copy_addr_gen
  import ram_copy_engine_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 load_down,
  input  logic [ADDR_SIZE-1:0] load_val,
  input  logic                 step,
  output logic [ADDR_SIZE-1:0] addr_nxt
);

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] ADDR_ZERO = {ADDR_SIZE{1'b0}};

  logic [ADDR_SIZE-1:0] ptr_r;
  logic                 down_r;
  logic [ADDR_SIZE-1:0] ptr_nxt_s;

  // Next pointer value; wraps naturally through the truncated width.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (load) begin
      ptr_nxt_s = load_val;
    end else if (step) begin
      ptr_nxt_s = down_r ? (ptr_r - ADDR_ONE) : (ptr_r + ADDR_ONE);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer and direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r  <= ADDR_ZERO;
      down_r <= 1'b0;
    end else begin
      ptr_r <= ptr_nxt_s;
      if (load) begin
        down_r <= load_down;
      end
    end
  end

  assign addr_nxt = ptr_nxt_s;

endmodule

// File: rtl/ram_copy_engine.sv
// Word-by-word RAM copy engine: alternating READ/WRITE cycles with overlap-safe direction.
module ram_copy_engine
  import ram_copy_engine_pkg::*;
#(
  parameter int WORDSIZE  = WORDSIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] src,
  input  logic [ADDR_SIZE-1:0] dst,
  input  logic [ADDR_SIZE:0]   len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORDSIZE-1:0]  ram_wdata,
  output logic                 ram_we,
  input  logic [WORDSIZE-1:0]  ram_rdata
);

  localparam logic [ADDR_SIZE:0]   LEN_MAX   = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0]   LEN_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0]   LEN_ZERO  = {(ADDR_SIZE+1){1'b0}};
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0] ADDR_ZERO = {ADDR_SIZE{1'b0}};
  localparam logic [WORDSIZE-1:0]  WORD_ZERO = {WORDSIZE{1'b0}};

  copy_state_t          state_r, state_nxt_s;
  logic [ADDR_SIZE:0]   rem_r;
  logic [ADDR_SIZE:0]   len_clamp_s;
  logic [ADDR_SIZE-1:0] len_m1_s, diff_s, src_start_s, dst_start_s;
  logic [ADDR_SIZE-1:0] src_nxt_s, dst_nxt_s;
  logic                 desc_s, load_s, step_s;
  logic                 busy_r, done_r, ram_we_r;
  logic [ADDR_SIZE-1:0] ram_addr_r;
  logic [WORDSIZE-1:0]  buffer_r;

  // Clamp length, choose direction and the first pointer values of a new request.
  always_comb begin
    if (len > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = len;
    end
    len_m1_s = len_clamp_s[ADDR_SIZE-1:0] - ADDR_ONE;
    diff_s   = dst - src;
    desc_s   = overlap_desc(32'(diff_s), 32'(len_clamp_s));
    if (desc_s) begin
      src_start_s = src + len_m1_s;
      dst_start_s = dst + len_m1_s;
    end else begin
      src_start_s = src;
      dst_start_s = dst;
    end
  end

  // Next-state logic; pointers load on acceptance and step on each write.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = (len_clamp_s == LEN_ZERO) ? ST_DONE : ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ:  state_nxt_s = ST_WRITE;
      ST_WRITE: begin
        step_s      = 1'b1;
        state_nxt_s = (rem_r == LEN_ONE) ? ST_DONE : ST_READ;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  ram_copy_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_src_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_down(desc_s),
    .load_val (src_start_s),
    .step     (step_s),
    .addr_nxt (src_nxt_s)
  );

  ram_copy_addr_gen #(.ADDR_SIZE(ADDR_SIZE)) u_dst_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_down(desc_s),
    .load_val (dst_start_s),
    .step     (step_s),
    .addr_nxt (dst_nxt_s)
  );

  // State, remaining count and registered RAM-side outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rem_r      <= LEN_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ram_we_r   <= 1'b0;
      ram_addr_r <= ADDR_ZERO;
      buffer_r   <= WORD_ZERO;
    end else begin
      state_r  <= state_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
      done_r   <= (state_nxt_s == ST_DONE);
      ram_we_r <= (state_nxt_s == ST_WRITE);
      if (load_s) begin
        rem_r <= len_clamp_s;
      end else if (step_s) begin
        rem_r <= rem_r - LEN_ONE;
      end
      case (state_nxt_s)
        ST_READ:  ram_addr_r <= src_nxt_s;
        ST_WRITE: ram_addr_r <= dst_nxt_s;
        default:  ram_addr_r <= ram_addr_r;
      endcase
      if (state_r == ST_READ) begin
        buffer_r <= ram_rdata;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = buffer_r;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Table-driven bench for ram_copy_engine with a 64x8 RAM model and read/write scoreboards.
module tb_ram_copy_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] src = 6'd0, dst = 6'd0;
  logic [6:0] len = 7'd0;
  logic       busy, done, ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  ram_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model with a one-cycle pattern preload port
  logic [7:0] mem [64];
  logic [7:0] model_mem [64];
  logic       pre_load = 1'b0;
  int         pre_base = 0, pre_off = 0;
  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (pre_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(pre_base + ((i - pre_off) & 63));
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  typedef struct packed { logic [5:0] addr; logic [7:0] data; } wr_t;
  wr_t        wq[$];
  logic [5:0] rq[$];
  wr_t        e;
  int n_vec = 0, n_miss = 0;
  int we_cnt = 0, first_wa = -1;
  bit done_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: writes and read-phase addresses are popped as the DUT produces them
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_seen = 1'b1;
      if (ram_we) begin
        if (we_cnt == 0) first_wa = int'(ram_addr);
        we_cnt++;
        check("write_expected", (wq.size() > 0) ? 1 : 0, 1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("waddr", int'(ram_addr), int'(e.addr));
          check("wdata", int'(ram_wdata), int'(e.data));
        end
      end else if (busy && !done) begin
        check("read_expected", (rq.size() > 0) ? 1 : 0, 1);
        if (rq.size() > 0) check("raddr", int'(ram_addr), int'(rq.pop_front()));
      end
    end
  end

  task automatic preload(input int base, input int off);
    @(negedge clk);
    pre_base = base; pre_off = off; pre_load = 1'b1;
    @(negedge clk);
    pre_load = 1'b0;
  endtask

  // Call just after a negedge; the next posedge is the acceptance edge
  task automatic run_copy(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l,
                          output int lat, output int nw);
    int lc, diff, sa, da;
    bit desc;
    lc   = (l > 7'd64) ? 64 : int'(l);
    diff = (int'(d) - int'(s)) & 63;
    desc = (diff != 0) && (diff < lc);
    for (int i = 0; i < 64; i++) model_mem[i] = mem[i];
    for (int k = 0; k < lc; k++) begin
      sa = desc ? ((int'(s) + lc - 1 - k) & 63) : ((int'(s) + k) & 63);
      da = desc ? ((int'(d) + lc - 1 - k) & 63) : ((int'(d) + k) & 63);
      rq.push_back(6'(sa));
      wq.push_back({6'(da), model_mem[sa]});
      model_mem[da] = model_mem[sa];
    end
    we_cnt = 0; first_wa = -1;
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    lat = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    nw = we_cnt;
    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("idle_after_done", int'(busy), 0);
    wq.delete(); rq.delete();
  endtask

  typedef struct {
    int base, off;
    logic [5:0] s, d;
    logic [6:0] l;
    int lat, nw, fw;
    bit mem_chk;
    int chk_a;
    logic [31:0] chk_d;
  } vec_t;

  vec_t vt [9];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nw, bad;
    vt[0] = '{0,     0,  6'd0,  6'd32, 7'd4,   9,   4,  32, 1, 32, {8'd3, 8'd2, 8'd1, 8'd0}};
    vt[1] = '{'hA1,  62, 6'd62, 6'd10, 7'd4,   9,   4,  10, 1, 10, {8'hA4, 8'hA3, 8'hA2, 8'hA1}};
    vt[2] = '{0,     0,  6'd0,  6'd2,  7'd4,   9,   4,  5,  1, 2,  {8'd3, 8'd2, 8'd1, 8'd0}};
    vt[3] = '{0,     0,  6'd5,  6'd5,  7'd3,   7,   3,  5,  1, 5,  {8'd8, 8'd7, 8'd6, 8'd5}};
    vt[4] = '{0,     0,  6'd3,  6'd9,  7'd0,   1,   0,  -1, 1, 9,  {8'd12, 8'd11, 8'd10, 8'd9}};
    vt[5] = '{'h40,  0,  6'd0,  6'd0,  7'd100, 129, 64, 0,  1, 0,  {8'h43, 8'h42, 8'h41, 8'h40}};
    vt[6] = '{0,     0,  6'd0,  6'd1,  7'd64,  129, 64, 0,  0, -1, 32'd0};
    vt[7] = '{0,     0,  6'd60, 6'd2,  7'd8,   17,  8,  9,  1, 2,  {8'd63, 8'd62, 8'd61, 8'd60}};
    vt[8] = '{0,     0,  6'd10, 6'd4,  7'd5,   11,  5,  4,  1, 4,  {8'd13, 8'd12, 8'd11, 8'd10}};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(ram_we), 0);
    check("rst_addr", int'(ram_addr), 0);
    check("rst_wdata", int'(ram_wdata), 0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      preload(vt[v].base, vt[v].off);
      run_copy(vt[v].s, vt[v].d, vt[v].l, lat, nw);
      check($sformatf("v%0d_latency", v), lat, vt[v].lat);
      check($sformatf("v%0d_writes", v), nw, vt[v].nw);
      check($sformatf("v%0d_first_waddr", v), first_wa, vt[v].fw);
      if (vt[v].mem_chk) begin
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== model_mem[i]) bad++;
        check($sformatf("v%0d_mem_bad_words", v), bad, 0);
      end
      if (vt[v].chk_a >= 0) begin
        for (int j = 0; j < 4; j++)
          check($sformatf("v%0d_ram[%0d]", v, (vt[v].chk_a + j) & 63),
                int'(mem[(vt[v].chk_a + j) & 63]), int'(vt[v].chk_d[8*j +: 8]));
      end
    end

    // start pulses and input changes mid-copy must be ignored
    preload(0, 0);
    fork
      run_copy(6'd0, 6'd48, 7'd4, lat, nw);
      begin
        repeat (3) @(negedge clk);
        src = 6'd7; dst = 6'd20; len = 7'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("busy_start_latency", lat, 9);
    check("busy_start_writes", nw, 4);
    check("busy_start_ram48", int'(mem[48]), 0);
    check("busy_start_ram51", int'(mem[51]), 3);
    check("busy_start_ram20", int'(mem[20]), 20);

    // reset during the WRITE cycle after two completed writes of an 8-word copy
    preload(0, 0);
    done_seen = 1'b0;
    rq.push_back(6'd0); rq.push_back(6'd1); rq.push_back(6'd2);
    wq.push_back({6'd40, 8'd0}); wq.push_back({6'd41, 8'd1});
    src = 6'd0; dst = 6'd40; len = 7'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("pre_rst_we", int'(ram_we), 1);
    rst = 1'b1;
    #1 check("rst_we_drop", int'(ram_we), 0);
    check("rst_busy_drop", int'(busy), 0);
    check("rst_addr_clear", int'(ram_addr), 0);
    repeat (3) @(negedge clk);
    check("rst_no_done", int'(done_seen), 0);
    check("rst_wq_consumed", wq.size(), 0);
    check("rst_rq_consumed", rq.size(), 0);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (int'(mem[i]) != ((i == 40) ? 0 : (i == 41) ? 1 : i)) bad++;
    check("rst_mem_bad_words", bad, 0);
    wq.delete(); rq.delete();
    @(negedge clk);
    rst = 1'b0;
    run_copy(6'd4, 6'd56, 7'd3, lat, nw);
    check("post_rst_latency", lat, 7);
    check("post_rst_writes", nw, 3);
    check("post_rst_ram56", int'(mem[56]), 4);
    check("post_rst_ram58", int'(mem[58]), 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
